// File: rtl/nn_mac_pkg.sv
// Shared constants and sequencer state encoding for the neuron MAC datapath.
// Operand/accumulator widths are shared with the DSP MAC wrapper.
package nn_mac_pkg;

   localparam int DATA_W = 18;
   localparam int ACC_W  = 48;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FETCH = 3'd2,
      S_LOAD  = 3'd3,
      S_ISSUE = 3'd4,
      S_DRAIN = 3'd5,
      S_DONE  = 3'd6
   } state_t;

endpackage

// File: rtl/mac_term_counter.sv
// Load/increment counter that saturates at a terminal count LAST.
// Ports: clk, reset (sync, active-high), load (clear to 0), inc, count, last.
module mac_term_counter #(
   parameter int WIDTH = 10,
   parameter int LAST  = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic             last
);

   localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

   always_ff @(posedge clk) begin
      if (reset || load)
         count <= '0;
      else if (inc && !last)
         count <= count + 1'b1;
   end

   assign last = (count == LAST_V);

endmodule

// File: rtl/mac_sequencer.sv
// Walks pixel/weight memories, feeds one operand pair per term to the MAC,
// waits out the MAC pipeline and captures the accumulated dot product.
// Ports: clk, reset (sync, active-high), start, busy, done, result;
// memory side mem_addr, mem_rd_en, pixel_data, weight_data;
// MAC side mac_clear, mac_data_a, mac_data_b, mac_start_operation, mac_data_p.
module mac_sequencer
   import nn_mac_pkg::*;
#(
   parameter int VECTOR_LENGTH = 784,
   parameter int ADDR_WIDTH    = 10,
   parameter int DATA_WIDTH    = DATA_W,
   parameter int ACC_WIDTH     = ACC_W,
   parameter int MAC_LATENCY   = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ACC_WIDTH-1:0]  result,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd_en,
   input  logic [DATA_WIDTH-1:0] pixel_data,
   input  logic [DATA_WIDTH-1:0] weight_data,
   output logic                  mac_clear,
   output logic [DATA_WIDTH-1:0] mac_data_a,
   output logic [DATA_WIDTH-1:0] mac_data_b,
   output logic                  mac_start_operation,
   input  logic [ACC_WIDTH-1:0]  mac_data_p
);

   localparam int DRAIN_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

   state_t state;
   state_t state_nx;

   logic [ADDR_WIDTH-1:0] term_idx;
   logic                  term_last;
   logic                  term_load;
   logic                  term_inc;
   logic [DRAIN_W-1:0]    drain_cnt;
   logic                  drain_last;
   logic                  drain_load;
   logic                  drain_inc;
   logic                  unused_drain;

   mac_term_counter #(
      .WIDTH (ADDR_WIDTH),
      .LAST  (VECTOR_LENGTH - 1)
   ) u_term (
      .clk   (clk),
      .reset (reset),
      .load  (term_load),
      .inc   (term_inc),
      .count (term_idx),
      .last  (term_last)
   );

   mac_term_counter #(
      .WIDTH (DRAIN_W),
      .LAST  (MAC_LATENCY - 1)
   ) u_drain (
      .clk   (clk),
      .reset (reset),
      .load  (drain_load),
      .inc   (drain_inc),
      .count (drain_cnt),
      .last  (drain_last)
   );

   // Only the terminal flag of the drain counter steers the FSM.
   assign unused_drain = ^drain_cnt;

   always_ff @(posedge clk) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // Operands change only in LOAD, so they are stable through ISSUE and
   // the following FETCH, giving the MAC two quiet cycles after each pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         mac_data_a <= '0;
         mac_data_b <= '0;
         result     <= '0;
      end else begin
         if (state == S_LOAD) begin
            mac_data_a <= pixel_data;
            mac_data_b <= weight_data;
         end
         if (state == S_DRAIN && drain_last)
            result <= mac_data_p;
      end
   end

   always_comb begin
      state_nx            = state;
      busy                = 1'b1;
      done                = 1'b0;
      mac_clear           = 1'b0;
      mem_rd_en           = 1'b0;
      mem_addr            = '0;
      mac_start_operation = 1'b0;
      term_load           = 1'b0;
      term_inc            = 1'b0;
      drain_load          = 1'b0;
      drain_inc           = 1'b0;
      unique case (state)
         S_IDLE: begin
            busy      = 1'b0;
            term_load = 1'b1;
            if (start)
               state_nx = S_CLEAR;
         end
         S_CLEAR: begin
            mac_clear = 1'b1;
            state_nx  = S_FETCH;
         end
         S_FETCH: begin
            mem_rd_en = 1'b1;
            mem_addr  = term_idx;
            state_nx  = S_LOAD;
         end
         S_LOAD: begin
            state_nx = S_ISSUE;
         end
         S_ISSUE: begin
            mac_start_operation = 1'b1;
            if (term_last) begin
               drain_load = 1'b1;
               state_nx   = S_DRAIN;
            end else begin
               term_inc = 1'b1;
               state_nx = S_FETCH;
            end
         end
         S_DRAIN: begin
            drain_inc = 1'b1;
            if (drain_last)
               state_nx = S_DONE;
         end
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench: three sequencers (N=4, 2, 1) share one memory pair
// and one behavioural 3-cycle MAC; the active instance is chosen by sel.
module tb_mac_sequencer;

   typedef struct {
      logic signed [47:0] res;
      int                 cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  start_v;
   logic [2:0]  busy_v;
   logic [2:0]  done_v;
   logic [2:0]  rd_v;
   logic [2:0]  clr_v;
   logic [2:0]  pulse_v;
   logic [47:0] res_v  [3];
   logic [9:0]  addr_v [3];
   logic [17:0] a_v    [3];
   logic [17:0] b_v    [3];

   logic [17:0] pix_d;
   logic [17:0] wgt_d;
   logic [47:0] mac_p;

   logic signed [17:0] pix [4];
   logic signed [17:0] wgt [4];

   int sel;
   int cyc = 0;
   int t0 = 0;
   int ndone = 0;
   int errors = 0;
   int checks = 0;

   int   pulse_q [$];
   int   clr_q   [$];
   exp_t exp_q   [$];

   logic        done_s, rd_s, clr_s, pulse_s;
   logic [47:0] res_s;
   logic [9:0]  addr_s;
   logic [17:0] a_s, b_s;

   logic signed [47:0] acc, d0, d1;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mac_sequencer #(
         .VECTOR_LENGTH ((g == 0) ? 4 : ((g == 1) ? 2 : 1)),
         .ADDR_WIDTH    (10),
         .DATA_WIDTH    (18),
         .ACC_WIDTH     (48),
         .MAC_LATENCY   (3)
      ) u_dut (
         .clk                 (clk),
         .reset               (reset),
         .start               (start_v[g]),
         .busy                (busy_v[g]),
         .done                (done_v[g]),
         .result              (res_v[g]),
         .mem_addr            (addr_v[g]),
         .mem_rd_en           (rd_v[g]),
         .pixel_data          (pix_d),
         .weight_data         (wgt_d),
         .mac_clear           (clr_v[g]),
         .mac_data_a          (a_v[g]),
         .mac_data_b          (b_v[g]),
         .mac_start_operation (pulse_v[g]),
         .mac_data_p          (mac_p)
      );
   end

   always_comb begin
      done_s  = done_v[sel];
      rd_s    = rd_v[sel];
      clr_s   = clr_v[sel];
      pulse_s = pulse_v[sel];
      res_s   = res_v[sel];
      addr_s  = addr_v[sel];
      a_s     = a_v[sel];
      b_s     = b_v[sel];
   end

   // Memories: read data returns one cycle after the strobe.
   always @(posedge clk) begin
      if (rd_s) begin
         pix_d <= pix[addr_s[1:0]];
         wgt_d <= wgt[addr_s[1:0]];
      end
   end

   // Behavioural MAC: sum visible 3 cycles after the pulse.
   always @(posedge clk) begin
      if (reset || clr_s) begin
         acc <= '0;
         d0  <= '0;
         d1  <= '0;
      end else begin
         if (pulse_s)
            acc <= acc + ($signed(a_s) * $signed(b_s));
         d0 <= acc;
         d1 <= d0;
      end
   end
   assign mac_p = d1;

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Scoreboard pop on each done of the active instance.
   always @(negedge clk) begin
      exp_t e;
      if (pulse_s) pulse_q.push_back(cyc - t0);
      if (clr_s) clr_q.push_back(cyc - t0);
      if (done_s) begin
         ndone++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_done: observed done at %0d expected none",
                   cyc - t0);
         end else begin
            e = exp_q.pop_front();
            chk("result", $signed(res_s), e.res);
            chk("done_cycle", cyc - t0, e.cyc);
         end
      end
   end

   task automatic load(input int p0, input int p1, input int p2, input int p3,
                       input int w0, input int w1, input int w2, input int w3);
      pix[0] = 18'(p0); pix[1] = 18'(p1); pix[2] = 18'(p2); pix[3] = 18'(p3);
      wgt[0] = 18'(w0); wgt[1] = 18'(w1); wgt[2] = 18'(w2); wgt[3] = 18'(w3);
   endtask

   task automatic kick(input int inst, input int n, input longint expv,
                       input bit track, input bit hold);
      exp_t e;
      @(posedge clk);
      #1;
      sel = inst;
      pulse_q.delete();
      clr_q.delete();
      t0 = cyc;
      start_v[inst] = 1'b1;
      if (track) begin
         e.res = expv[47:0];
         e.cyc = 3 * n + 2 + 3;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (!hold) start_v[inst] = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done_s) begin
            ok = 1'b1;
            break;
         end
      end
      #1;
      chk(tag, ok, 1);
   endtask

   initial begin
      int nd0;
      exp_t e;
      reset   = 1'b1;
      start_v = '0;
      sel     = 0;
      load(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy_v, 0);
      chk("rst_done", done_v, 0);
      chk("rst_pulse", pulse_v, 0);
      chk("rst_clear", clr_v, 0);
      chk("rst_rd_en", rd_v, 0);
      chk("rst_result", res_v[0], 0);
      reset = 1'b0;

      // Basic dot product
      load(1, 2, 3, 4, 5, 6, 7, 8);
      kick(0, 4, 70, 1, 0);
      wait_done("t1_timeout");
      chk("t1_npulse", pulse_q.size(), 4);
      chk("t1_pulse0", pulse_q[0], 4);
      chk("t1_pulse1", pulse_q[1], 7);
      chk("t1_pulse2", pulse_q[2], 10);
      chk("t1_pulse3", pulse_q[3], 13);
      chk("t1_nclear", clr_q.size(), 1);
      chk("t1_clear_cyc", clr_q[0], 1);

      // Signed operands
      load(-3, 2, 0, 0, 4, -5, 0, 0);
      kick(1, 2, -22, 1, 0);
      wait_done("t2_timeout");
      chk("t2_npulse", pulse_q.size(), 2);
      chk("t2_raw", res_v[1], 48'hFFFF_FFFF_FFEA);

      // Back-to-back runs
      load(1, 2, 3, 4, 5, 6, 7, 8);
      kick(0, 4, 70, 1, 0);
      wait_done("t3a_timeout");
      load(1, 1, 1, 1, 2, 2, 2, 2);
      kick(0, 4, 8, 1, 0);
      wait_done("t3b_timeout");
      chk("t3_nclear", clr_q.size(), 1);
      chk("t3_clear_cyc", clr_q[0], 1);

      // Start held high for the whole run
      nd0 = ndone;
      kick(0, 4, 8, 1, 1);
      wait_done("t4_timeout");
      chk("t4_npulse", pulse_q.size(), 4);
      chk("t4_ndone", ndone - nd0, 1);
      @(posedge clk);
      #1;
      chk("t4_idle_busy", busy_v[0], 0);
      @(posedge clk);
      #1;
      chk("t4_restart_busy", busy_v[0], 1);
      start_v[0] = 1'b0;
      t0 = cyc - 1;
      e.res = 48'sd8;
      e.cyc = 17;
      exp_q.push_back(e);
      wait_done("t4b_timeout");

      // Reset mid-run
      load(1, 2, 3, 4, 5, 6, 7, 8);
      nd0 = ndone;
      kick(0, 4, 0, 0, 0);
      repeat (6) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("t5_busy", busy_v[0], 0);
      chk("t5_done", done_v[0], 0);
      chk("t5_result", res_v[0], 0);
      chk("t5_pulse", pulse_v[0], 0);
      repeat (20) @(posedge clk);
      #1;
      chk("t5_no_done", ndone - nd0, 0);
      kick(0, 4, 70, 1, 0);
      wait_done("t5_timeout");

      // Single term, extreme operands
      load(131071, 0, 0, 0, -131072, 0, 0, 0);
      kick(2, 1, -64'sd17179738112, 1, 0);
      wait_done("t6_timeout");
      chk("t6_npulse", pulse_q.size(), 1);
      chk("t6_pulse0", pulse_q[0], 4);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
